regfile_wr_arbiter: RTL and testbench

Round-robin write-port arbiter and sequencer for the CPU's 16-bit general register file. Three writers compete for the single write port: ALU writeback, memory load return and the debug/host port. The block grants one writer per cycle and registers the winning address and data into a one-hot register-enable vector plus a shared data bus. These drive the `en`/`d` inputs of the register cells directly. A saturating contention counter supports performance debug.

---
 rtl/regfile_wr_arbiter.sv | 122 ++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin arbiter for the register file write port.
// Three writers (ALU, load, debug) share one registered one-hot write stage.
module regfile_wr_arbiter #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned NREG    = 8,
  parameter int unsigned AW      = 3,
  parameter bit          R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [2:0]        req,
  input  logic [AW-1:0]     addr0,
  input  logic [AW-1:0]     addr1,
  input  logic [AW-1:0]     addr2,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  output logic [2:0]        gnt,
  output logic [NREG-1:0]   wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] contention
);

  logic [1:0]        last;
  logic [1:0]        c1;
  logic [1:0]        c2;
  logic [1:0]        c3;
  logic [1:0]        win;
  logic [AW-1:0]     sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   dec;
  logic              multi;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign c1 = nxt(last);
  assign c2 = nxt(c1);
  assign c3 = last;

  assign multi = (req[0] & req[1]) |
                 (req[0] & req[2]) |
                 (req[1] & req[2]);

  // Rotating-priority search starting just after the last winner
  always_comb begin
    gnt = '0;
    win = last;
    if (!reset && !stall) begin
      if (req[c1]) begin
        gnt[c1] = 1'b1;
        win     = c1;
      end else if (req[c2]) begin
        gnt[c2] = 1'b1;
        win     = c2;
      end else if (req[c3]) begin
        gnt[c3] = 1'b1;
        win     = c3;
      end
    end
  end

  // Select the winner's address/data and decode the register enable
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    unique case (1'b1)
      gnt[0]: begin
        sel_addr = addr0;
        sel_data = data0;
      end
      gnt[1]: begin
        sel_addr = addr1;
        sel_data = data1;
      end
      gnt[2]: begin
        sel_addr = addr2;
        sel_data = data2;
      end
      default: ;
    endcase
    dec = '0;
    dec[sel_addr] = 1'b1;
    if (R0_ZERO && sel_addr == '0) begin
      dec = '0;
    end
  end

  // Winner pointer: advances only on an actual grant
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= 2'd2;
    end else if (|gnt) begin
      last <= win;
    end
  end

  // Write stage: enable pulses for one cycle, data holds between writes
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en   <= '0;
      wr_data <= '0;
    end else if (|gnt) begin
      wr_en   <= dec;
      wr_data <= sel_data;
    end else begin
      wr_en   <= '0;
    end
  end

  // Saturating count of unstalled cycles with competing requests
  always_ff @(posedge clk) begin
    if (reset) begin
      contention <= '0;
    end else if (!stall && multi && contention != '1) begin
      contention <= contention + 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed vectors for the register write arbiter.
// Three builds share stimulus: R0 hard-wired, R0 writable, 4-bit counter.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [2:0]  req;
  logic [2:0]  addr0, addr1, addr2;
  logic [15:0] data0, data1, data2;

  logic [2:0]  a_gnt, b_gnt, c_gnt;
  logic [7:0]  a_wr_en, b_wr_en, c_wr_en;
  logic [15:0] a_wr_data, b_wr_data;
  logic [15:0] a_cnt, b_cnt;
  logic [3:0]  c_wr_data, c_cnt;

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(
    .DATA_W(16), .NREG(8), .AW(3), .R0_ZERO(1'b1)
  ) u_a (
    .clk(clk), .reset(reset), .stall(stall), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .data0(data0), .data1(data1), .data2(data2),
    .gnt(a_gnt), .wr_en(a_wr_en), .wr_data(a_wr_data),
    .contention(a_cnt)
  );

  regfile_wr_arbiter #(
    .DATA_W(16), .NREG(8), .AW(3), .R0_ZERO(1'b0)
  ) u_b (
    .clk(clk), .reset(reset), .stall(stall), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .data0(data0), .data1(data1), .data2(data2),
    .gnt(b_gnt), .wr_en(b_wr_en), .wr_data(b_wr_data),
    .contention(b_cnt)
  );

  regfile_wr_arbiter #(
    .DATA_W(4), .NREG(8), .AW(3), .R0_ZERO(1'b1)
  ) u_c (
    .clk(clk), .reset(reset), .stall(stall), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .data0(data0[3:0]), .data1(data1[3:0]), .data2(data2[3:0]),
    .gnt(c_gnt), .wr_en(c_wr_en), .wr_data(c_wr_data),
    .contention(c_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    ntotal++;
    if (got === exp) begin
      npass++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    req   = 3'b111;
    addr0 = 3'd1;
    addr1 = 3'd2;
    addr2 = 3'd4;
    data0 = 16'hAAAA;
    data1 = 16'hBBBB;
    data2 = 16'hCCCC;
    settle();
    check("rst_gnt", a_gnt, 3'b000);
    tick();
    tick();
    check("rst_wr_en", a_wr_en, 8'h00);
    check("rst_wr_data", a_wr_data, 16'h0000);
    check("rst_cnt", a_cnt, 16'd0);

    reset = 1'b0;
    settle();
    check("rr_gnt0", a_gnt, 3'b001);
    tick();
    check("rr_en0", a_wr_en, 8'b0000_0010);
    check("rr_d0", a_wr_data, 16'hAAAA);
    check("rr_cnt1", a_cnt, 16'd1);
    check("rr_gnt1", a_gnt, 3'b010);
    tick();
    check("rr_en1", a_wr_en, 8'b0000_0100);
    check("rr_d1", a_wr_data, 16'hBBBB);
    check("rr_gnt2", a_gnt, 3'b100);
    tick();
    check("rr_en2", a_wr_en, 8'b0001_0000);
    check("rr_d2", a_wr_data, 16'hCCCC);
    check("rr_cnt3", a_cnt, 16'd3);
    check("rr_gnt3", a_gnt, 3'b001);

    req   = 3'b010;
    addr1 = 3'd5;
    data1 = 16'hBEEF;
    settle();
    check("sw_gnt", a_gnt, 3'b010);
    tick();
    check("sw_en", a_wr_en, 8'b0010_0000);
    check("sw_d", a_wr_data, 16'hBEEF);
    req = 3'b000;
    settle();
    check("sw_gnt_idle", a_gnt, 3'b000);
    tick();
    check("sw_en_off", a_wr_en, 8'h00);
    check("sw_d_hold", a_wr_data, 16'hBEEF);
    check("sw_cnt", a_cnt, 16'd3);

    req   = 3'b001;
    addr0 = 3'd0;
    data0 = 16'h1234;
    settle();
    check("r0_gnt", a_gnt, 3'b001);
    tick();
    check("r0_en", a_wr_en, 8'h00);
    check("r0_d", a_wr_data, 16'h1234);
    check("r0_off_en", b_wr_en, 8'b0000_0001);

    req   = 3'b100;
    addr2 = 3'd7;
    data2 = 16'h7777;
    settle();
    check("dbg_gnt", a_gnt, 3'b100);
    tick();
    check("dbg_en", a_wr_en, 8'b1000_0000);

    req   = 3'b011;
    addr0 = 3'd6;
    data0 = 16'h0606;
    stall = 1'b1;
    settle();
    check("st_gnt0", a_gnt, 3'b000);
    tick();
    check("st_en0", a_wr_en, 8'h00);
    check("st_cnt0", a_cnt, 16'd3);
    check("st_gnt1", a_gnt, 3'b000);
    tick();
    check("st_en1", a_wr_en, 8'h00);
    check("st_cnt1", a_cnt, 16'd3);
    stall = 1'b0;
    settle();
    check("st_rel_gnt0", a_gnt, 3'b001);
    tick();
    check("st_rel_en0", a_wr_en, 8'b0100_0000);
    check("st_rel_gnt1", a_gnt, 3'b010);
    tick();
    check("st_rel_en1", a_wr_en, 8'b0010_0000);
    check("st_rel_cnt", a_cnt, 16'd5);

    req = 3'b101;
    for (int k = 0; k < 20; k++) begin
      settle();
      if (k < 4) begin
        check("sat_gnt", c_gnt, (k % 2 == 0) ? 3'b100 : 3'b001);
      end
      tick();
      if (k == 9) begin
        check("sat_cnt15", c_cnt, 4'd15);
      end
    end
    check("sat_hold", c_cnt, 4'd15);
    check("wide_cnt", a_cnt, 16'd25);

    req   = 3'b010;
    addr1 = 3'd3;
    data1 = 16'h3333;
    settle();
    check("mr_gnt", a_gnt, 3'b010);
    tick();
    check("mr_en", a_wr_en, 8'b0000_1000);
    reset = 1'b1;
    req   = 3'b111;
    addr0 = 3'd2;
    settle();
    check("mr_gnt_rst", a_gnt, 3'b000);
    tick();
    check("mr_en_clr", a_wr_en, 8'h00);
    check("mr_cnt_clr", a_cnt, 16'd0);
    check("mr_d_clr", a_wr_data, 16'h0000);
    reset = 1'b0;
    settle();
    check("mr_last2", a_gnt, 3'b001);
    tick();
    check("mr_en_after", a_wr_en, 8'b0000_0100);
    req = 3'b000;
    tick();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
